// File: rtl/fifo_uart_streamer.sv
// rtl/fifo_uart_streamer.sv - pops FIFO words and frames them as header + MSB-first bytes onto uart_tx.
// Optional CHECKSUM_EN appends an XOR byte over header and data bytes.
module fifo_uart_streamer #(
    parameter int          DATA_WIDTH  = 32,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5,
    parameter int          WCNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_ff_empty,
    input  logic [DATA_WIDTH-1:0] i_ff_data,
    output logic                  o_ff_rden,
    input  logic                  i_sig_comp,
    input  logic                  i_tx_active,
    input  logic                  i_tx_done,
    output logic                  o_tx_send,
    output logic [7:0]            o_tx_byte,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [WCNT_WIDTH-1:0] o_word_count
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IW     = $clog2(NBYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_HDR,
        S_DATA,
`ifdef CHECKSUM_EN
        S_CSUM,
`endif
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   word_q;
    logic [IW-1:0]           idx_q;
    logic                    last_q;
    logic                    rden_q;
    logic                    send_q;
    logic [7:0]              byte_q;
    logic                    done_q;
    logic [WCNT_WIDTH-1:0]   cnt_q;
`ifdef CHECKSUM_EN
    logic [7:0]              csum_q;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            rden_q  <= 1'b0;
            send_q  <= 1'b0;
            byte_q  <= 8'h00;
            done_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            rden_q <= 1'b0;
            send_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!i_ff_empty) begin
                        rden_q  <= 1'b1;
                        state_q <= S_POP;
                    end else if (i_sig_comp) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_POP: state_q <= S_LATCH;
                S_LATCH: begin
                    word_q  <= i_ff_data;
                    idx_q   <= '0;
                    last_q  <= 1'b0;
`ifdef CHECKSUM_EN
                    csum_q  <= HEADER_BYTE;
`endif
                    state_q <= S_HDR;
                end
                S_HDR: begin
                    if (!i_tx_active) begin
                        byte_q  <= HEADER_BYTE;
                        send_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_DATA: begin
                    // word_q shifts left so the next byte to send is always the top byte
                    if (!i_tx_active) begin
                        byte_q  <= word_q[DATA_WIDTH-1 -: 8];
                        word_q  <= word_q << 8;
                        idx_q   <= idx_q + IW'(1);
`ifdef CHECKSUM_EN
                        csum_q  <= csum_q ^ word_q[DATA_WIDTH-1 -: 8];
`else
                        last_q  <= (idx_q == IW'(NBYTES - 1));
`endif
                        send_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
`ifdef CHECKSUM_EN
                S_CSUM: begin
                    if (!i_tx_active) begin
                        byte_q  <= csum_q;
                        last_q  <= 1'b1;
                        send_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
`endif
                S_WAIT: begin
                    if (i_tx_done) begin
                        if (last_q) begin
                            if (cnt_q != {WCNT_WIDTH{1'b1}})
                                cnt_q <= cnt_q + WCNT_WIDTH'(1);
                            state_q <= S_IDLE;
`ifdef CHECKSUM_EN
                        end else if (idx_q == IW'(NBYTES)) begin
                            state_q <= S_CSUM;
`endif
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DONE:  done_q  <= 1'b1;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ff_rden    = rden_q;
    assign o_tx_send    = send_q;
    assign o_tx_byte    = byte_q;
    assign o_done       = done_q;
    assign o_word_count = cnt_q;
    assign o_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
endmodule

// File: tb/tb_fifo_uart_streamer.sv
// tb/tb_fifo_uart_streamer.sv - scoreboard bench with FIFO and uart_tx models for fifo_uart_streamer.
module tb_fifo_uart_streamer;
    localparam int DW  = 32;
    localparam int NB  = DW / 8;
    localparam int WCW = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic            ff_empty;
    logic [DW-1:0]   ff_data;
    logic            ff_rden;
    logic            sig_comp;
    logic            tx_active;
    logic            tx_done;
    logic            tx_send;
    logic [7:0]      tx_byte;
    logic            busy;
    logic            done;
    logic [WCW-1:0]  word_count;

    fifo_uart_streamer #(.DATA_WIDTH(DW), .HEADER_BYTE(8'hA5), .WCNT_WIDTH(WCW)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_ff_empty(ff_empty), .i_ff_data(ff_data),
        .o_ff_rden(ff_rden), .i_sig_comp(sig_comp), .i_tx_active(tx_active),
        .i_tx_done(tx_done), .o_tx_send(tx_send), .o_tx_byte(tx_byte),
        .o_busy(busy), .o_done(done), .o_word_count(word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fifo_q[$];
    logic [7:0]    exp_q[$];
    int            ff_level  = 0;
    int            exp_words = 0;
    int            nsent     = 0;
    int            nrden     = 0;
    logic          pending   = 1'b0;
    logic          prev_send = 1'b0;
    logic [7:0]    cur_byte  = 8'h00;
    int            lat_max   = 3;
    int            bp_min    = 0;
    int            bp_max    = 0;

    assign ff_empty = (ff_level == 0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        logic [7:0] b;
        logic [7:0] x;
        fifo_q.push_back(w);
        ff_level++;
        exp_q.push_back(8'hA5);
        x = 8'hA5;
        for (int i = NB - 1; i >= 0; i--) begin
            b = 8'((w >> (8 * i)) & 32'hFF);
            exp_q.push_back(b);
            x = x ^ b;
        end
`ifdef CHECKSUM_EN
        exp_q.push_back(x);
`endif
        exp_words++;
    endtask

    function automatic logic [63:0] sat_count(input int n);
        return (n > (1 << WCW) - 1) ? 64'((1 << WCW) - 1) : 64'(n);
    endfunction

    // FIFO read port model: data appears the cycle after the pop strobe
    always @(posedge clk) begin
        if (ff_rden && fifo_q.size() > 0) begin
            ff_data <= fifo_q.pop_front();
            ff_level = ff_level - 1;
        end
    end

    // uart_tx model with random byte time and optional post-byte busy hold
    int tx_cnt  = 0;
    int tx_hold = 0;
    always @(posedge clk) begin
        if (!rstn) begin
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            tx_cnt    = 0;
            tx_hold   = 0;
        end else begin
            tx_done <= 1'b0;
            if (tx_send) begin
                tx_active <= 1'b1;
                tx_cnt    = $urandom_range(lat_max, 1);
            end else if (tx_cnt != 0) begin
                tx_cnt = tx_cnt - 1;
                if (tx_cnt == 0) begin
                    tx_done <= 1'b1;
                    tx_hold = (bp_max > 0) ? $urandom_range(bp_max, bp_min) : 0;
                    if (tx_hold == 0) tx_active <= 1'b0;
                end
            end else if (tx_hold != 0) begin
                tx_hold = tx_hold - 1;
                if (tx_hold == 0) tx_active <= 1'b0;
            end
        end
    end

    // monitor: pops the scoreboard on every send and checks the handshake rules
    always @(negedge clk) begin
        if (!rstn) begin
            pending   = 1'b0;
            prev_send = 1'b0;
        end else begin
            if (ff_rden) begin
                nrden++;
                check("rden_while_empty", 64'(ff_empty), 64'd0);
            end
            if (tx_send) begin
                nsent++;
                check("send_while_active", 64'(tx_active), 64'd0);
                check("send_back_to_back", 64'(prev_send), 64'd0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL byte_unexpected actual=%0h required=none", tx_byte);
                end else begin
                    check("tx_byte", 64'(tx_byte), 64'(exp_q.pop_front()));
                end
                cur_byte = tx_byte;
                pending  = 1'b1;
            end else if (pending) begin
                check("byte_hold", 64'(tx_byte), 64'(cur_byte));
                if (tx_done) pending = 1'b0;
            end
            prev_send = tx_send;
        end
    end

    task automatic do_reset(input logic sc);
        rstn = 1'b0;
        sig_comp = sc;
        fifo_q.delete();
        exp_q.delete();
        ff_level  = 0;
        exp_words = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wait_quiet(input string name, input int budget);
        int n = 0;
        while (!(!busy && ff_level == 0 && !pending) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 64'(n < budget), 64'd1);
        check({name, "_leftover"}, 64'(exp_q.size()), 64'd0);
        check({name, "_count"}, 64'(word_count), sat_count(exp_words));
    endtask

    initial begin
        ff_data = '0;
        do_reset(1'b0);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_rden", 64'(ff_rden), 64'd0);
        check("rst_send", 64'(tx_send), 64'd0);
        check("rst_byte", 64'(tx_byte), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        rstn = 1'b1;

        push_word(32'h1234_ABCD);
        wait_quiet("single", 500);

        lat_max = 12; bp_min = 0; bp_max = 20;
        for (int i = 0; i < 10; i++) begin
            push_word($urandom);
            repeat ($urandom_range(40, 0)) @(negedge clk);
        end
        wait_quiet("random", 20000);

        lat_max = 4; bp_min = 500; bp_max = 500;
        push_word($urandom);
        push_word($urandom);
        wait_quiet("backpressure", 20000);

        lat_max = 3; bp_min = 0; bp_max = 0;
        do_reset(1'b0);
        nsent = 0;
        push_word($urandom);
        for (int n = 0; n < 500 && nsent < 3; n++) @(negedge clk);
        check("midreset_reached", 64'(nsent >= 3), 64'd1);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("async_rst_send", 64'(tx_send), 64'd0);
        check("async_rst_byte", 64'(tx_byte), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_count", 64'(word_count), 64'd0);
        do_reset(1'b0);
        push_word(32'hDEAD_0001);
        wait_quiet("after_reset", 500);

        do_reset(1'b0);
        repeat (1000) @(negedge clk);
        check("empty_no_done", 64'(done), 64'd0);
        sig_comp = 1'b1;
        repeat (2) @(negedge clk);
        check("empty_done", 64'(done), 64'd1);
        check("empty_done_busy", 64'(busy), 64'd0);
        nrden = 0;
        fifo_q.push_back(32'h5555_AAAA);
        ff_level++;
        repeat (50) @(negedge clk);
        check("done_terminal_rden", 64'(nrden), 64'd0);
        check("done_terminal_sends", 64'(done), 64'd1);

        rstn = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        ff_level = 0;
        exp_words = 0;
        sig_comp = 1'b1;
        push_word(32'h0102_0304);
        push_word(32'hF0E0_D0C0);
        push_word(32'h8000_0001);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int n = 0; n < 3000 && !done; n++) @(negedge clk);
        check("drain_done", 64'(done), 64'd1);
        check("drain_count", 64'(word_count), 64'd3);
        check("drain_leftover", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
